// File: rtl/vga_pkg.sv
// Shared constants, fetch FSM state type and the fixed RGB332 expansion
// used by the VGA line fetcher.
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int H_LAST         = 799;
  localparam int V_LAST         = 524;
  localparam int WORDS_PER_LINE = 320;
  localparam int WC_W           = 9;
  localparam int LB_IDX_W       = $clog2(2 * WORDS_PER_LINE);

  typedef enum logic {
    IDLE,
    REQ
  } fetch_state_t;

  // Replicate the 3/3/2 colour fields so full-scale indices reach 8'hFF.
  function automatic logic [23:0] rgb332(input logic [7:0] i);
    return {i[7:5], i[7:5], i[7:6],
            i[4:2], i[4:2], i[4:3],
            {4{i[1:0]}}};
  endfunction

endpackage

// File: rtl/vga_line_buffer.sv
// Ping-pong line store: two 320-word halves, fetch-side write port and a
// registered display-side read port.
module vga_line_buffer
  import vga_pkg::*;
(
  input  logic            clk,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [WC_W-1:0] wr_word,
  input  logic [15:0]     wr_data,
  input  logic            rd_en,
  input  logic            rd_sel,
  input  logic [WC_W-1:0] rd_word,
  output logic [15:0]     rd_data
);

  logic [15:0]         mem [2 * WORDS_PER_LINE];
  logic [15:0]         rd_data_q;
  logic [LB_IDX_W-1:0] wr_idx;
  logic [LB_IDX_W-1:0] rd_idx;

  // Second half starts at word 320, so the select bit is an offset, not an MSB.
  assign wr_idx = wr_sel ? LB_IDX_W'(WORDS_PER_LINE) + LB_IDX_W'(wr_word)
                         : LB_IDX_W'(wr_word);
  assign rd_idx = rd_sel ? LB_IDX_W'(WORDS_PER_LINE) + LB_IDX_W'(rd_word)
                         : LB_IDX_W'(rd_word);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_line_fetcher.sv
// Fetches the next scanline one line ahead of the beam and drives RGB/blank.
// Define VGA_FETCH_PALETTE_EN for a writable 256x24 palette; else RGB332.
module vga_line_fetcher
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 18,
  parameter int FB_BASE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              pal_we,
  input  logic [7:0]        pal_idx,
  input  logic [23:0]       pal_rgb,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              blank_out,
  output logic              underrun
);

  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_LINE - 1);

  logic              pixel_clk_q;
  logic              ps;
  logic [9:0]        nxt;
  logic              trigger;
  logic [ADDR_W-1:0] nxt_ext;
  logic [ADDR_W-1:0] line_base;

  fetch_state_t      state_q, state_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              buf_sel_q, buf_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              underrun_q, underrun_d;
  logic              wr_en;

  logic              byte_sel_q, byte_sel_d;
  logic              blank1_q, blank1_d;
  logic              blank2_q, blank2_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              blank_out_q, blank_out_d;
  logic [15:0]       rd_data;
  logic [7:0]        pix_idx;
  logic [23:0]       pal_q;

  assign ps      = pixel_clk & ~pixel_clk_q;
  assign nxt     = (DrawY == 10'(V_LAST)) ? 10'd0 : DrawY + 10'd1;
  assign trigger = ps && (int'(DrawX) == H_ACTIVE) && (int'(nxt) < V_ACTIVE);

  // nxt*320 as two shifts; the sum wraps at the memory address width.
  assign nxt_ext   = ADDR_W'(nxt);
  assign line_base = ADDR_W'(FB_BASE) + (nxt_ext << 8) + (nxt_ext << 6);

  always_comb begin
    state_d    = state_q;
    wc_d       = wc_q;
    buf_sel_d  = buf_sel_q;
    mem_addr_d = mem_addr_q;
    underrun_d = underrun_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d    = REQ;
          wc_d       = '0;
          buf_sel_d  = nxt[0];
          mem_addr_d = line_base;
        end
      end
      REQ: begin
        if (trigger) begin
          // Previous line did not finish in time: flag it and start over.
          underrun_d = 1'b1;
          wc_d       = '0;
          buf_sel_d  = nxt[0];
          mem_addr_d = line_base;
        end else if (mem_ack) begin
          if (wc_q == WC_LAST) begin
            state_d = IDLE;
            wc_d    = '0;
          end else begin
            wc_d       = wc_q + WC_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_clk_q <= 1'b0;
      state_q     <= IDLE;
      wc_q        <= '0;
      buf_sel_q   <= 1'b0;
      mem_addr_q  <= '0;
      underrun_q  <= 1'b0;
    end else begin
      pixel_clk_q <= pixel_clk;
      state_q     <= state_d;
      wc_q        <= wc_d;
      buf_sel_q   <= buf_sel_d;
      mem_addr_q  <= mem_addr_d;
      underrun_q  <= underrun_d;
    end
  end

  assign mem_req  = (state_q == REQ);
  assign mem_addr = mem_addr_q;
  assign underrun = underrun_q;
  assign wr_en    = (state_q == REQ) && mem_ack;

  vga_line_buffer u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_sel  (buf_sel_q),
    .wr_word (wc_q),
    .wr_data (mem_rdata),
    .rd_en   (ps & blank),
    .rd_sel  (DrawY[0]),
    .rd_word (DrawX[9:1]),
    .rd_data (rd_data)
  );

  assign pix_idx = byte_sel_q ? rd_data[15:8] : rd_data[7:0];

`ifdef VGA_FETCH_PALETTE_EN
  logic [23:0] pal_mem [256];

  always_ff @(posedge clk) begin
    if (pal_we) begin
      pal_mem[pal_idx] <= pal_rgb;
    end
    if (ps) begin
      pal_q <= pal_mem[pix_idx];
    end
  end
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_idx, pal_rgb};

  always_ff @(posedge clk) begin
    if (ps) begin
      pal_q <= rgb332(pix_idx);
    end
  end
`endif

  // Blank travels alongside the three pixel stages; colour is gated at the end.
  always_comb begin
    byte_sel_d  = byte_sel_q;
    blank1_d    = blank1_q;
    blank2_d    = blank2_q;
    rgb_d       = rgb_q;
    blank_out_d = blank_out_q;
    if (ps) begin
      byte_sel_d  = blank ? DrawX[0] : byte_sel_q;
      blank1_d    = blank;
      blank2_d    = blank1_q;
      rgb_d       = blank2_q ? pal_q : 24'h0;
      blank_out_d = blank2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_sel_q  <= 1'b0;
      blank1_q    <= 1'b0;
      blank2_q    <= 1'b0;
      rgb_q       <= '0;
      blank_out_q <= 1'b0;
    end else begin
      byte_sel_q  <= byte_sel_d;
      blank1_q    <= blank1_d;
      blank2_q    <= blank2_d;
      rgb_q       <= rgb_d;
      blank_out_q <= blank_out_d;
    end
  end

  assign VGA_R     = rgb_q[23:16];
  assign VGA_G     = rgb_q[15:8];
  assign VGA_B     = rgb_q[7:0];
  assign blank_out = blank_out_q;

endmodule
